// File: rtl/booth_mul_seq_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states and the
// per-iteration recoding of the multiplier bit pair.
package booth_mul_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Radix-2 recoding of {current LSB, previously shifted-out bit}
  function automatic booth_op_t booth_op(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b10:   return OP_SUB;
      2'b01:   return OP_ADD;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Request/response bundle between the operand registers and the multiplier.
interface booth_mul_seq_if #(
  parameter int WIDTH = 8
) ();

  logic                 start;
  logic                 abort;
  logic                 signed_i;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   Y;
  logic                 busy;
  logic                 valid;

  modport master (
    output start, abort, signed_i, A, B,
    input  Y, busy, valid
  );

  modport slave (
    input  start, abort, signed_i, A, B,
    output Y, busy, valid
  );

endinterface

// File: rtl/booth_mul_seq_step.sv
// One combinational Booth iteration: conditional add/sub of the multiplicand
// into the high half, then a one-bit arithmetic shift of {hi,lo,q_m1}.
module booth_step
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] hi_i,
  input  logic [WIDTH:0]   lo_i,
  input  logic             qm1_i,
  input  logic [WIDTH:0]   bx_i,
  output logic [WIDTH+1:0] hi_o,
  output logic [WIDTH:0]   lo_o,
  output logic             qm1_o
);

  logic [WIDTH+1:0] bx_sx;
  logic [WIDTH+1:0] sum;

  always_comb begin
    bx_sx = {bx_i[WIDTH], bx_i};
    case (booth_op(lo_i[0], qm1_i))
      OP_ADD:  sum = hi_i + bx_sx;
      OP_SUB:  sum = hi_i - bx_sx;
      default: sum = hi_i;
    endcase
    // The guard bit keeps the sum's sign valid, so replicating it is a true ASR.
    hi_o  = {sum[WIDTH+1], sum[WIDTH+1:1]};
    lo_o  = {sum[0], lo_i[WIDTH:1]};
    qm1_o = lo_i[0];
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier with signed/unsigned mode, abort and a
// fixed WIDTH+1 step latency. Holds the FSM, operand latches and result regs.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic           clk,
  input  logic           rst,
  booth_mul_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(WIDTH + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH+1:0]     hi_q, hi_d;
  logic [WIDTH:0]       lo_q, lo_d;
  logic                 qm1_q, qm1_d;
  logic [WIDTH:0]       bx_q, bx_d;
  logic [2*WIDTH-1:0]   y_q, y_d;
  logic                 valid_q, valid_d;

  logic [WIDTH+1:0]     step_hi;
  logic [WIDTH:0]       step_lo;
  logic                 step_qm1;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .qm1_i (qm1_q),
    .bx_i  (bx_q),
    .hi_o  (step_hi),
    .lo_o  (step_lo),
    .qm1_o (step_qm1)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qm1_d   = qm1_q;
    bx_d    = bx_q;
    y_d     = y_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Extending to WIDTH+1 bits latches the mode into the operands themselves.
          state_d = CALC;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = {bus.signed_i & bus.A[WIDTH-1], bus.A};
          bx_d    = {bus.signed_i & bus.B[WIDTH-1], bus.B};
          qm1_d   = 1'b0;
        end
      end
      CALC: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          qm1_d = step_qm1;
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            y_d     = {step_hi[WIDTH-2:0], step_lo};
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qm1_q   <= 1'b0;
      bx_q    <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
      bx_q    <= bx_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Y     = y_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q == CALC);

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: directed handshake/abort/reset cases on an 8-bit
// instance and randomized products on a 16-bit instance against integer math.
module tb_booth_mul_seq;

  logic clk, rst;
  int   n_tot, n_bad;

  booth_mul_seq_if #(.WIDTH(8))  b8 ();
  booth_mul_seq_if #(.WIDTH(16)) b16 ();

  booth_mul_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
  booth_mul_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer product of the operands as interpreted by mode
  function automatic logic [63:0] ref_mul(input int w, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sgn,
                      output logic [15:0] y, output int lat);
    @(negedge clk);
    b8.A = a; b8.B = b; b8.signed_i = sgn; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    b8.A = 8'($urandom); b8.B = 8'($urandom); b8.signed_i = 1'($urandom);
    chk("busy8", 64'(b8.busy), 64'd1);
    lat = 0;
    while (!b8.valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    y = b8.Y;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit sgn,
                       output logic [31:0] y, output int lat);
    @(negedge clk);
    b16.A = a; b16.B = b; b16.signed_i = sgn; b16.start = 1'b1;
    @(negedge clk);
    b16.start = 1'b0;
    b16.A = 16'($urandom); b16.B = 16'($urandom); b16.signed_i = 1'($urandom);
    lat = 0;
    while (!b16.valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    y = b16.Y;
  endtask

  initial begin
    logic [15:0] y8;
    logic [31:0] y16;
    logic [7:0]  ta[4], tb[4];
    bit          ts[4];
    logic [15:0] ra, rb;
    bit          rs;
    int          lat;
    bit          seen;

    n_tot = 0; n_bad = 0;
    rst = 1'b0;
    b8.start = 0;  b8.abort = 0;  b8.signed_i = 0;  b8.A = '0;  b8.B = '0;
    b16.start = 0; b16.abort = 0; b16.signed_i = 0; b16.A = '0; b16.B = '0;
    repeat (2) @(negedge clk);
    chk("rst Y",     64'(b8.Y), 64'd0);
    chk("rst valid", 64'(b8.valid), 64'd0);
    chk("rst busy",  64'(b8.busy), 64'd0);
    chk("rst Y16",   64'(b16.Y), 64'd0);
    rst = 1'b1;

    // 99*99 unsigned, latency and pulse width
    run8(8'd99, 8'd99, 1'b0, y8, lat);
    chk("t1 y",   64'(y8), ref_mul(8, 0, 32'd99, 32'd99));
    chk("t1 lat", 64'(lat), 64'd9);
    @(negedge clk);
    chk("t1 pulse", 64'(b8.valid), 64'd0);
    chk("t1 hold",  64'(b8.Y), 64'h2649);

    ta = '{8'd255, 8'h80, 8'hFF, 8'd0};
    tb = '{8'd255, 8'h80, 8'd127, 8'hFB};
    ts = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run8(ta[i], tb[i], ts[i], y8, lat);
      chk("t2 y", 64'(y8), ref_mul(8, ts[i], 32'(ta[i]), 32'(tb[i])));
    end
    chk("t2 const", 64'(ref_mul(8, 1, 32'h80, 32'h80)), 64'h4000);

    // start held high: only first accepted; second start on the valid cycle
    @(negedge clk);
    b8.A = 8'd20; b8.B = 8'd30; b8.signed_i = 1'b0; b8.start = 1'b1;
    @(negedge clk);
    lat = 0;
    b8.A = 8'($urandom); b8.B = 8'($urandom);
    while (!b8.valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!b8.valid) begin b8.A = 8'($urandom); b8.B = 8'($urandom); end
    end
    chk("t3 y1",   64'(b8.Y), 64'd600);
    chk("t3 lat1", 64'(lat), 64'd9);
    b8.A = 8'd7; b8.B = 8'hFD; b8.signed_i = 1'b1;
    @(negedge clk);
    b8.start = 1'b0; b8.A = 8'($urandom); b8.B = 8'($urandom); b8.signed_i = 1'b0;
    chk("t3 busy2", 64'(b8.busy), 64'd1);
    lat = 0;
    while (!b8.valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t3 y2",   64'(b8.Y), ref_mul(8, 1, 32'd7, 32'hFD));
    chk("t3 lat2", 64'(lat), 64'd9);

    // abort after step 3, landing on the 4th step edge
    @(negedge clk);
    b8.A = 8'd50; b8.B = 8'd50; b8.signed_i = 1'b0; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (3) @(negedge clk);
    b8.abort = 1'b1;
    @(negedge clk);
    b8.abort = 1'b0;
    chk("t4 busy",  64'(b8.busy), 64'd0);
    chk("t4 valid", 64'(b8.valid), 64'd0);
    chk("t4 Y",     64'(b8.Y), 64'hFFEB);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (b8.valid) seen = 1;
    end
    chk("t4 novalid", 64'(seen), 64'd0);
    b8.abort = 1'b1;
    @(negedge clk);
    b8.abort = 1'b0;
    chk("t4 idle abort busy", 64'(b8.busy), 64'd0);
    chk("t4 idle abort Y",    64'(b8.Y), 64'hFFEB);
    // abort together with start while idle: start wins
    b8.A = 8'd9; b8.B = 8'd9; b8.start = 1'b1; b8.abort = 1'b1;
    @(negedge clk);
    b8.start = 1'b0; b8.abort = 1'b0;
    chk("t4 sa busy", 64'(b8.busy), 64'd1);
    lat = 0;
    while (!b8.valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t4 sa y",   64'(b8.Y), 64'd81);
    chk("t4 sa lat", 64'(lat), 64'd9);

    // reset in the middle of an operation
    b8.A = 8'd33; b8.B = 8'd44; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t4 rst Y",     64'(b8.Y), 64'd0);
    chk("t4 rst busy",  64'(b8.busy), 64'd0);
    chk("t4 rst valid", 64'(b8.valid), 64'd0);
    rst = 1'b1;

    // 16-bit corners
    run16(16'h8000, 16'h8000, 1'b1, y16, lat);
    chk("t5 smin", 64'(y16), 64'h40000000);
    chk("t5 lat",  64'(lat), 64'd17);
    run16(16'hFFFF, 16'hFFFF, 1'b0, y16, lat);
    chk("t5 umax", 64'(y16), 64'hFFFE0001);
    run16(16'hFFFF, 16'h0001, 1'b1, y16, lat);
    chk("t5 neg1", 64'(y16), ref_mul(16, 1, 32'hFFFF, 32'h1));

    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      run16(ra, rb, rs, y16, lat);
      chk("t5 rand", 64'(y16), ref_mul(16, rs, 32'(ra), 32'(rb)));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
